// File: rtl/quad_enc_counter.sv
// rtl/quad_enc_counter.sv - quadrature encoder counter with sync, glitch filter, 4x decode and index handling
module quad_enc_counter #(
    parameter int WIDTH    = 18,
    parameter int FILT_LEN = 3,
    parameter int IDX_MODE = 0,
    parameter int SAT      = 0
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [1:0]       Enc,
    input  logic             Enc_I,
    input  logic             Clr,
    input  logic             Err_Clr,
    output logic [WIDTH-1:0] Count,
    output logic             Dir,
    output logic             Step,
    output logic             Err,
    output logic [WIDTH-1:0] Index_Latch,
    output logic             Index_Valid
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    localparam logic [3:0]       FILT_LAST = 4'(FILT_LEN - 1);
    localparam logic [4:0]       INIT_LAST = 5'(FILT_LEN);
    localparam logic [WIDTH-1:0] CNT_MAX   = '1;

    state_t           state, state_nxt;
    logic [2:0]       pin_raw;      // {B, A, I}
    logic [2:0]       sync1, sync2;
    logic [2:0]       filt;
    logic [3:0]       filt_cnt [3];
    logic [4:0]       init_cnt;
    logic             init_done;
    logic [1:0]       enc_old;
    logic             idx_old;

    logic [1:0]       enc_cur;
    logic             run;
    logic             step_up, step_dn, illegal, idx_rise;
    logic             idx_clr, idx_lat;
    logic [WIDTH-1:0] count_stepped;
    logic [WIDTH-1:0] count_nxt;

    assign pin_raw = {Enc[1], Enc[0], Enc_I};

    // Two-flop synchroniser for all three pins
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pin_raw;
            sync2 <= sync1;
        end
    end

    // Startup stability counter; one extra cycle guards against the reset-zeroed synchroniser looking stable
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            init_cnt <= '0;
        end else if (state != ST_INIT || sync1 != sync2) begin
            init_cnt <= '0;
        end else if (!init_done) begin
            init_cnt <= init_cnt + 5'd1;
        end
    end

    assign init_done = (state == ST_INIT) && (sync1 == sync2) && (init_cnt == INIT_LAST);

    // Decode state register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: leave INIT once the pins have settled; RUN is terminal until reset
    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: if (init_done) state_nxt = ST_RUN;
            default: state_nxt = ST_RUN;
        endcase
    end

    // Per-pin stability filter; tracks the synchronised pins directly while in INIT
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            filt <= '0;
            for (int i = 0; i < 3; i++) filt_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (state == ST_INIT) begin
                    filt[i]     <= sync2[i];
                    filt_cnt[i] <= '0;
                end else if (sync2[i] != filt[i]) begin
                    if (filt_cnt[i] == FILT_LAST) begin
                        filt[i]     <= sync2[i];
                        filt_cnt[i] <= '0;
                    end else begin
                        filt_cnt[i] <= filt_cnt[i] + 4'd1;
                    end
                end else begin
                    filt_cnt[i] <= '0;
                end
            end
        end
    end

    // Previous-state registers; primed from the synchroniser in INIT so startup levels never decode
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            enc_old <= '0;
            idx_old <= 1'b0;
        end else if (state == ST_INIT) begin
            enc_old <= sync2[2:1];
            idx_old <= sync2[0];
        end else begin
            enc_old <= filt[2:1];
            idx_old <= filt[0];
        end
    end

    // 4x decode, overflow arithmetic and index resolution
    always_comb begin
        enc_cur = filt[2:1];
        run     = (state == ST_RUN);
        step_up = 1'b0;
        step_dn = 1'b0;
        if (run) begin
            case ({enc_old, enc_cur})
                4'b0001, 4'b0111, 4'b1110, 4'b1000: step_up = 1'b1;
                4'b0100, 4'b1101, 4'b1011, 4'b0010: step_dn = 1'b1;
                default: ;
            endcase
        end
        illegal  = run && (enc_cur == ~enc_old);
        idx_rise = run && filt[0] && !idx_old;

        count_stepped = Count;
        if (step_up) begin
            if (SAT != 0 && Count == CNT_MAX) count_stepped = Count;
            else                              count_stepped = Count + WIDTH'(1);
        end else if (step_dn) begin
            if (SAT != 0 && Count == '0)      count_stepped = Count;
            else                              count_stepped = Count - WIDTH'(1);
        end

        idx_clr   = (IDX_MODE == 1) && idx_rise;
        idx_lat   = (IDX_MODE == 2) && idx_rise;
        count_nxt = idx_clr ? '0 : count_stepped;
    end

    // Output registers: Clr outranks index clear, which outranks stepping
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Count       <= '0;
            Dir         <= 1'b0;
            Step        <= 1'b0;
            Err         <= 1'b0;
            Index_Latch <= '0;
            Index_Valid <= 1'b0;
        end else if (Clr) begin
            Count       <= '0;
            Dir         <= 1'b0;
            Step        <= 1'b0;
            Err         <= 1'b0;
            Index_Latch <= '0;
            Index_Valid <= 1'b0;
        end else begin
            Count       <= count_nxt;
            Step        <= step_up | step_dn;
            Index_Valid <= idx_clr | idx_lat;
            if (step_up | step_dn) Dir <= step_up;
            if (illegal)           Err <= 1'b1;
            else if (Err_Clr)      Err <= 1'b0;
            if (idx_lat)           Index_Latch <= count_stepped;
        end
    end

endmodule

// File: tb/tb_quad_enc_counter.sv
// tb/tb_quad_enc_counter.sv - directed self-checking bench for quad_enc_counter
module tb_quad_enc_counter;

    localparam int FL = 3;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic [1:0] Enc;
    logic       Enc_I;
    logic       Clr;
    logic       Err_Clr;

    logic [17:0] c1, l1, c2, l2;
    logic        d1, st1, e1, v1, d2, st2, e2, v2;
    logic [3:0]  cw, lw, cs, ls;
    logic        dw, stw, ew, vw, ds, sts, es, vs;

    int checks = 0;
    int errors = 0;
    int ph;
    logic [1:0] gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    int st1_cnt = 0;
    int v1_cnt  = 0;
    int v2_cnt  = 0;
    int sts_cnt = 0;

    quad_enc_counter #(.WIDTH(18), .FILT_LEN(FL), .IDX_MODE(1), .SAT(0)) u_m1 (
        .Clk(Clk), .Rst_n(Rst_n), .Enc(Enc), .Enc_I(Enc_I), .Clr(Clr), .Err_Clr(Err_Clr),
        .Count(c1), .Dir(d1), .Step(st1), .Err(e1), .Index_Latch(l1), .Index_Valid(v1));

    quad_enc_counter #(.WIDTH(18), .FILT_LEN(FL), .IDX_MODE(2), .SAT(0)) u_m2 (
        .Clk(Clk), .Rst_n(Rst_n), .Enc(Enc), .Enc_I(Enc_I), .Clr(Clr), .Err_Clr(Err_Clr),
        .Count(c2), .Dir(d2), .Step(st2), .Err(e2), .Index_Latch(l2), .Index_Valid(v2));

    quad_enc_counter #(.WIDTH(4), .FILT_LEN(FL), .IDX_MODE(0), .SAT(0)) u_wrap (
        .Clk(Clk), .Rst_n(Rst_n), .Enc(Enc), .Enc_I(Enc_I), .Clr(Clr), .Err_Clr(Err_Clr),
        .Count(cw), .Dir(dw), .Step(stw), .Err(ew), .Index_Latch(lw), .Index_Valid(vw));

    quad_enc_counter #(.WIDTH(4), .FILT_LEN(FL), .IDX_MODE(0), .SAT(1)) u_sat (
        .Clk(Clk), .Rst_n(Rst_n), .Enc(Enc), .Enc_I(Enc_I), .Clr(Clr), .Err_Clr(Err_Clr),
        .Count(cs), .Dir(ds), .Step(sts), .Err(es), .Index_Latch(ls), .Index_Valid(vs));

    always #5 Clk = ~Clk;

    // Free-running pulse counters; tasks compare deltas over windows
    always @(negedge Clk) begin
        if (st1 === 1'b1) st1_cnt <= st1_cnt + 1;
        if (v1  === 1'b1) v1_cnt  <= v1_cnt + 1;
        if (v2  === 1'b1) v2_cnt  <= v2_cnt + 1;
        if (sts === 1'b1) sts_cnt <= sts_cnt + 1;
    end

    task automatic step_enc(input bit up, input int hold, input bit chk);
        ph = up ? (ph + 1) % 4 : (ph + 3) % 4;
        @(posedge Clk); #1 Enc = gray[ph];
        for (int i = 1; i <= hold; i++) begin
            @(posedge Clk); @(negedge Clk);
            if (chk && i == FL + 2) begin
                checks++;
                if (st1 !== 1'b0) begin
                    errors++;
                    $display("FAIL step_early edge=%0d got %b exp 0", i, st1);
                end
            end
            if (chk && i == FL + 3) begin
                checks++;
                if (st1 !== 1'b1 || d1 !== up) begin
                    errors++;
                    $display("FAIL step_latency_dir got step=%b dir=%b exp step=1 dir=%b", st1, d1, up);
                end
            end
        end
    endtask

    task automatic settle();
        repeat (4) @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic do_clr();
        @(posedge Clk); #1 Clr = 1'b1;
        @(posedge Clk); #1 Clr = 1'b0;
    endtask

    task automatic test_reset();
        int sc, vc1, vc2;
        bit bad;
        Rst_n = 1'b0; Enc = 2'b11; Enc_I = 1'b1; Clr = 1'b0; Err_Clr = 1'b0; ph = 2;
        repeat (4) @(posedge Clk);
        @(negedge Clk);
        checks++;
        if ({c1, d1, st1, e1, l1, v1} !== '0 || {c2, l2, v2} !== '0) begin
            errors++;
            $display("FAIL reset_state got c1=%0d e1=%b l2=%0d exp all 0", c1, e1, l2);
        end
        @(posedge Clk); #1 Rst_n = 1'b1;
        sc = st1_cnt; vc1 = v1_cnt; vc2 = v2_cnt; bad = 0;
        repeat (50) begin
            @(negedge Clk);
            if (c1 !== 18'd0 || e1 !== 1'b0 || st1 !== 1'b0 || v1 !== 1'b0 || v2 !== 1'b0 || e2 !== 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL prime_quiet got c1=%0d e1=%b exp 0 0 with no pulses", c1, e1);
        end
        checks++;
        if (st1_cnt != sc || v1_cnt != vc1 || v2_cnt != vc2) begin
            errors++;
            $display("FAIL prime_pulses got steps=%0d idx=%0d exp 0 0", st1_cnt - sc, v1_cnt - vc1 + v2_cnt - vc2);
        end
        @(posedge Clk); #1 Enc_I = 1'b0;
        repeat (10) @(posedge Clk);
    endtask

    task automatic test_fwd_rev();
        repeat (40) step_enc(1'b1, 10, 1'b1);
        checks++;
        if (c1 !== 18'd40 || c2 !== 18'd40) begin
            errors++;
            $display("FAIL fwd_count got %0d/%0d exp 40", c1, c2);
        end
        checks++;
        if (cw !== 4'd8 || cs !== 4'd15) begin
            errors++;
            $display("FAIL fwd_narrow got wrap=%0d sat=%0d exp 8 15", cw, cs);
        end
        repeat (15) step_enc(1'b0, 10, 1'b1);
        checks++;
        if (c1 !== 18'd25) begin
            errors++;
            $display("FAIL rev_count got %0d exp 25", c1);
        end
    endtask

    task automatic test_glitch_illegal();
        logic [17:0] bef;
        int sc;
        bef = c1; sc = st1_cnt;
        @(posedge Clk); #1 Enc[0] = ~Enc[0];
        @(posedge Clk); @(posedge Clk); #1 Enc[0] = ~Enc[0];
        repeat (15) @(negedge Clk);
        checks++;
        if (c1 !== bef || st1_cnt != sc || e1 !== 1'b0) begin
            errors++;
            $display("FAIL glitch got count=%0d steps=%0d err=%b exp %0d 0 0", c1, st1_cnt - sc, e1, bef);
        end
        while (ph != 0) step_enc(1'b1, 10, 1'b0);
        bef = c1;
        @(posedge Clk); #1 Enc = 2'b11; ph = 2;
        repeat (10) @(posedge Clk);
        @(negedge Clk);
        checks++;
        if (e1 !== 1'b1 || ew !== 1'b1 || c1 !== bef) begin
            errors++;
            $display("FAIL illegal got err=%b count=%0d exp 1 %0d", e1, c1, bef);
        end
        @(posedge Clk); #1 Err_Clr = 1'b1;
        @(posedge Clk); #1 Err_Clr = 1'b0;
        @(negedge Clk);
        checks++;
        if (e1 !== 1'b0) begin
            errors++;
            $display("FAIL err_clr got %b exp 0", e1);
        end
    endtask

    task automatic test_wrap_sat();
        int sc;
        do_clr();
        repeat (16) step_enc(1'b1, 5, 1'b0);
        settle();
        checks++;
        if (cw !== 4'd0) begin
            errors++;
            $display("FAIL wrap_up got %0d exp 0", cw);
        end
        step_enc(1'b0, 5, 1'b0);
        settle();
        checks++;
        if (cw !== 4'd15) begin
            errors++;
            $display("FAIL wrap_down got %0d exp 15", cw);
        end
        do_clr();
        sc = sts_cnt;
        repeat (20) step_enc(1'b1, 5, 1'b0);
        settle();
        checks++;
        if (cs !== 4'd15 || sts_cnt - sc != 20) begin
            errors++;
            $display("FAIL sat_up got count=%0d steps=%0d exp 15 20", cs, sts_cnt - sc);
        end
        repeat (20) step_enc(1'b0, 5, 1'b0);
        settle();
        checks++;
        if (cs !== 4'd0 || ds !== 1'b0) begin
            errors++;
            $display("FAIL sat_down got count=%0d dir=%b exp 0 0", cs, ds);
        end
    endtask

    task automatic test_index();
        int vc;
        do_clr();
        repeat (37) step_enc(1'b1, 5, 1'b0);
        settle();
        checks++;
        if (c1 !== 18'd37) begin
            errors++;
            $display("FAIL idx_pre got %0d exp 37", c1);
        end
        vc = v1_cnt;
        @(posedge Clk); #1 Enc_I = 1'b1;
        for (int i = 1; i <= FL + 3; i++) begin
            @(posedge Clk); @(negedge Clk);
            if (i == FL + 2) begin
                checks++;
                if (c1 !== 18'd37 || v1 !== 1'b0) begin
                    errors++;
                    $display("FAIL idx_early got count=%0d valid=%b exp 37 0", c1, v1);
                end
            end
        end
        checks++;
        if (c1 !== 18'd0 || v1 !== 1'b1) begin
            errors++;
            $display("FAIL idx_clear got count=%0d valid=%b exp 0 1", c1, v1);
        end
        checks++;
        if (l2 !== 18'd37 || c2 !== 18'd37 || v2 !== 1'b1) begin
            errors++;
            $display("FAIL idx_latch got latch=%0d count=%0d exp 37 37", l2, c2);
        end
        repeat (10) @(negedge Clk);
        checks++;
        if (v1_cnt - vc != 1) begin
            errors++;
            $display("FAIL idx_once got %0d pulses exp 1", v1_cnt - vc);
        end
        @(posedge Clk); #1 Enc_I = 1'b0;
        repeat (10) @(posedge Clk);

        do_clr();
        repeat (37) step_enc(1'b1, 5, 1'b0);
        settle();
        ph = (ph + 1) % 4;
        @(posedge Clk); #1 Enc = gray[ph]; Enc_I = 1'b1;
        repeat (FL + 3) @(posedge Clk);
        @(negedge Clk);
        checks++;
        if (c1 !== 18'd0) begin
            errors++;
            $display("FAIL idx_clr_coinc got %0d exp 0", c1);
        end
        checks++;
        if (l2 !== 18'd38 || c2 !== 18'd38 || v2 !== 1'b1) begin
            errors++;
            $display("FAIL idx_lat_coinc got latch=%0d count=%0d valid=%b exp 38 38 1", l2, c2, v2);
        end
        @(posedge Clk); #1 Enc_I = 1'b0;
        repeat (10) @(posedge Clk);
        step_enc(1'b1, 10, 1'b0);
        checks++;
        if (c2 !== 18'd39 || l2 !== 18'd38 || c1 !== 18'd1) begin
            errors++;
            $display("FAIL idx_continue got c2=%0d latch=%0d c1=%0d exp 39 38 1", c2, l2, c1);
        end
    endtask

    task automatic test_clr_reset();
        do_clr();
        repeat (100) step_enc(1'b1, 5, 1'b0);
        settle();
        checks++;
        if (c1 !== 18'd100) begin
            errors++;
            $display("FAIL clr_pre got %0d exp 100", c1);
        end
        ph = (ph + 1) % 4;
        @(posedge Clk); #1 Enc = gray[ph];
        @(posedge Clk); #1 Clr = 1'b1;
        @(posedge Clk); #1 Clr = 1'b0;
        @(negedge Clk);
        checks++;
        if (c1 !== 18'd0 || d1 !== 1'b0) begin
            errors++;
            $display("FAIL clr_mid got count=%0d dir=%b exp 0 0", c1, d1);
        end
        repeat (6) @(posedge Clk);
        @(negedge Clk);
        checks++;
        if (c1 !== 18'd1 || d1 !== 1'b1) begin
            errors++;
            $display("FAIL clr_resume got count=%0d dir=%b exp 1 1", c1, d1);
        end
        step_enc(1'b1, 10, 1'b0);
        checks++;
        if (c1 !== 18'd2) begin
            errors++;
            $display("FAIL rst_pre got %0d exp 2", c1);
        end
        ph = (ph + 1) % 4;
        @(posedge Clk); #1 Enc = gray[ph];
        @(posedge Clk); #3 Rst_n = 1'b0;
        #1;
        checks++;
        if ({c1, d1, st1, e1, l1, v1} !== '0 || c2 !== 18'd0 || l2 !== 18'd0 || cw !== 4'd0) begin
            errors++;
            $display("FAIL rst_async got c1=%0d d1=%b c2=%0d exp 0 0 0", c1, d1, c2);
        end
        @(posedge Clk); #1 Rst_n = 1'b1;
        repeat (2) @(posedge Clk);
    endtask

    initial begin
        test_reset();
        test_fwd_rev();
        test_glitch_illegal();
        test_wrap_sat();
        test_index();
        test_clr_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/quad_enc_counter.md
# quad_enc_counter

Parametrised quadrature encoder counter with input synchronisation, digital glitch filtering, full 4x decoding, illegal-transition detection and index-pulse handling. It converts the A/B/I encoder pins of one motor axis into a WIDTH-bit position count on the system clock. It is the position source for the PID loop, generalising the fixed 18-bit, 1x-rate encoder counter with configurable width, filtering, index behaviour and overflow mode.

## Interface

Parameters:
- WIDTH, 18: Count and Index_Latch width; valid range 2..32.
- FILT_LEN, 3: consecutive stable Clk samples a pin must hold before it is accepted; valid range 1..15.
- IDX_MODE, 0: index function. 0 ignores the index, 1 clears Count on the index, 2 latches Count on the index.
- SAT, 0: overflow mode. 0 wraps modulo 2^WIDTH; 1 saturates.

Ports:
- Clk, input, 1: system clock; all logic is on the rising edge.
- Rst_n, input, 1: asynchronous, active-low reset.
- Enc, input, 2: raw encoder pins, asynchronous to Clk. Enc[0] is A, Enc[1] is B.
- Enc_I, input, 1: raw index pin, asynchronous.
- Clr, input, 1: synchronous clear, active high.
- Err_Clr, input, 1: synchronous clear of Err only.
- Count, output, WIDTH: unsigned position count.
- Dir, output, 1: direction of the last valid step; 1 is up.
- Step, output, 1: one-cycle pulse on each valid count step.
- Err, output, 1: sticky flag for an illegal transition.
- Index_Latch, output, WIDTH: Count captured at the index (IDX_MODE 2).
- Index_Valid, output, 1: one-cycle pulse when Index_Latch updates, or when Count is cleared by the index.

## Operation

- Input path: A, B and I each pass through a 2-flop synchroniser, then a per-pin stability filter.
  - A filter output changes only after the synchronised value has differed from it for FILT_LEN consecutive cycles.
  - Any return to the current value resets that pin's stability counter.
- Decode state machine: INIT then RUN.
  - INIT is entered on reset. It waits until the synchronised {B,A,I} has been stable for FILT_LEN cycles.
  - It then loads the filter outputs and the previous-state register directly and goes to RUN.
  - INIT issues no Step, no Err and no index event, so pins that are high at reset never produce a spurious count.
- RUN decoding, with the state written as {B,A} and Enc_Old holding the previous state:
  - Up, +1, Dir=1: 00→01→11→10→00.
  - Down, −1, Dir=0: the reverse sequence.
  - No change: no action.
  - Both bits changed: Err←1, Count and Dir unchanged, no Step. Enc_Old still takes the new state.
- Overflow arithmetic:
  - SAT=0: up from 2^WIDTH−1 gives 0; down from 0 gives 2^WIDTH−1.
  - SAT=1: Count holds at 2^WIDTH−1 on up and at 0 on down. Step still pulses and Dir still updates.
- Index event: a rising edge of the filtered I in RUN.
  - IDX_MODE 1: Count←0 and Index_Valid pulses. If a step occurs in the same cycle, the clear wins and Count=0.
  - IDX_MODE 2: Index_Latch takes the value Count assumes in that cycle, including any coincident step, and Index_Valid pulses. Count itself is unaffected.
  - IDX_MODE 0: no action.
- Priority, highest first: Rst_n, Clr, index clear, step.
  - Clr sets Count, Dir, Err, Index_Latch and Index_Valid to 0 and suppresses Step that cycle.
  - Clr does not re-enter INIT.
- Err_Clr clears Err. An illegal transition in the same cycle wins, leaving Err=1.

## Timing

- Reset values while Rst_n is low:
  - All outputs are 0.
  - Synchroniser and filter registers are 0.
  - The state machine is in INIT.
- Pin-to-output latency is exactly FILT_LEN+3 Clk edges, counted from the first edge that samples the new pin level. Count, Dir, Step and Err all update on that edge.
  - The 3 fixed edges are synchroniser stage 1, synchroniser stage 2 and the output register.
  - The filter spends FILT_LEN edges qualifying the new level.
- Pulse rejection: a pin excursion lasting fewer than FILT_LEN synchronised cycles is rejected.
- Maximum trackable rate: one filtered transition per FILT_LEN+1 cycles. A faster input is allowed to alias into Err; it must never produce a silent miscount.
- Index latency is the same as the A/B path. Index_Valid is coincident with the Count or Index_Latch update.
- Clr and Err_Clr take effect on the next Clk edge, with no latency.
- Reset asserted mid-operation clears immediately and asynchronously. Deassertion must be synchronised externally; the block assumes it is clean to Clk.

## Test plan

- **Reset priming.** Hold Enc=11 and Enc_I=1 through reset, then release. Required: Count=0, Err=0, no Step and no Index_Valid for 50 cycles.
- **Forward then reverse, FILT_LEN=3.** Drive 40 forward 4x transitions, each held 10 cycles, then 15 reverse. Required:
  - Count=40 after the forward sweep, then 25.
  - Each Step fires exactly 6 edges after its pin change.
  - Dir is 1 during the forward sweep and 0 during the reverse.
- **Glitch and illegal transitions.**
  - A 2-cycle pulse on A is ignored.
  - A 00→11 jump sets Err=1 with Count unchanged.
  - Err_Clr returns Err to 0.
- **Wrap and saturate, WIDTH=4.**
  - SAT=0: 16 up steps from 0 give Count=0; one down step gives 15.
  - SAT=1: 20 up steps give 15; 20 down steps give 0.
- **Index modes.**
  - IDX_MODE 1 at Count=37: Count becomes 0 and Index_Valid pulses once.
  - IDX_MODE 1 with a coincident up-step: Count=0.
  - IDX_MODE 2 at Count=37 with a coincident up-step: Index_Latch=38, and Count keeps counting.
- **Clear and reset mid-run.**
  - Clr at Count=100 during motion gives Count=0 on the next edge, and counting resumes from 0.
  - Rst_n low mid-run zeroes all outputs asynchronously.
